// File: rtl/glb_proc_responder.sv
// Always-ready processor-packet responder: byte-strobed word storage with a fixed-latency read pipeline.
// Optional range checking of upper address bits is enabled by defining GLB_PROC_RESP_RANGE_CHECK_EN.
module glb_proc_responder #(
  parameter int unsigned BANK_DATA_WIDTH = 64,
  parameter int unsigned GLB_ADDR_WIDTH  = 22,
  parameter int unsigned DEPTH_LOG2      = 8,
  parameter int unsigned RD_LATENCY      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
  input  logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   wr_data,
  input  logic                         rd_en,
  input  logic [GLB_ADDR_WIDTH-1:0]    rd_addr,
  output logic [BANK_DATA_WIDTH-1:0]   rd_data,
  output logic                         rd_data_valid,
  output logic                         err_oor
);

  localparam int unsigned STRB_W   = BANK_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned DEPTH    = 32'(1) << DEPTH_LOG2;
  localparam int unsigned ADDR_TOP = ADDR_LSB + DEPTH_LOG2;

  logic [BANK_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]      wr_idx;
  logic [DEPTH_LOG2-1:0]      rd_idx;
  logic                       wr_oor;
  logic                       rd_oor;
  logic [BANK_DATA_WIDTH-1:0] rd_word;
  logic [RD_LATENCY-1:0]      vld_q;
  logic [BANK_DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic                       unused_addr;

  assign wr_idx      = wr_addr[ADDR_LSB +: DEPTH_LOG2];
  assign rd_idx      = rd_addr[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr = ^{wr_addr, rd_addr};

`ifdef GLB_PROC_RESP_RANGE_CHECK_EN
  assign wr_oor = |(wr_addr >> ADDR_TOP);
  assign rd_oor = |(rd_addr >> ADDR_TOP);

  // Sticky error: set by any out-of-range access, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_oor <= 1'b0;
    end else if ((wr_en && wr_oor) || (rd_en && rd_oor)) begin
      err_oor <= 1'b1;
    end
  end
`else
  // Upper address bits alias onto the storage.
  assign wr_oor  = 1'b0;
  assign rd_oor  = 1'b0;
  assign err_oor = 1'b0;
`endif

  // Storage is never reset; writes are gated by reset and range only.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && !wr_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Sampled before this edge's write lands, giving read-before-write.
  assign rd_word = rd_oor ? '0 : mem[rd_idx];

  // Read pipeline keeps data zeroed on empty slots so rd_data is 0 when not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      dat_q[0] <= rd_en ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_data_valid = vld_q[RD_LATENCY-1];
  assign rd_data       = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_glb_proc_responder.sv
// Directed self-checking bench for glb_proc_responder at default parameters (64-bit data, latency 2).
module tb_glb_proc_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_strb;
  logic [21:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [21:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        err_oor;

  int n_cmp = 0;
  int n_bad = 0;

  glb_proc_responder dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_strb       (wr_strb),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .err_oor       (err_oor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [21:0] a, input logic [63:0] d, input logic [7:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  // One read: nothing one cycle later, a single-cycle pulse two cycles later, then idle.
  task automatic read_check(input string tag, input logic [21:0] a, input logic [63:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_early_vld"}, 64'(rd_data_valid), 64'd0);
    tick();
    check({tag, "_vld"}, 64'(rd_data_valid), 64'd1);
    check({tag, "_data"}, rd_data, exp);
    tick();
    check({tag, "_after_vld"}, 64'(rd_data_valid), 64'd0);
    check({tag, "_after_data"}, rd_data, 64'd0);
  endtask

  logic [63:0] burst_exp [4];
  logic [63:0] word0;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_strb = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_vld", 64'(rd_data_valid), 64'd0);
    check("rst_data", rd_data, 64'd0);
    check("rst_err", 64'(err_oor), 64'd0);
    reset = 1'b0;
    tick();

    // Full write then read, plus byte-offset bits ignored.
    do_write(22'h10, 64'h1122334455667788, 8'hFF);
    read_check("full", 22'h10, 64'h1122334455667788);
    read_check("offset", 22'h13, 64'h1122334455667788);

    // Partial strobe and all-zero strobe no-op.
    do_write(22'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    read_check("strb0f", 22'h10, 64'h11223344BBBBBBBB);
    do_write(22'h10, 64'h0, 8'h00);
    read_check("strb00", 22'h10, 64'h11223344BBBBBBBB);

    // Same-cycle write/read returns old data; next-cycle read sees new data.
    wr_en = 1'b1; wr_addr = 22'h10; wr_data = '1; wr_strb = 8'hFF;
    rd_en = 1'b1; rd_addr = 22'h10;
    tick();
    wr_en = 1'b0;
    check("rbw_early_vld", 64'(rd_data_valid), 64'd0);
    tick();
    rd_en = 1'b0;
    check("rbw_vld", 64'(rd_data_valid), 64'd1);
    check("rbw_old", rd_data, 64'h11223344BBBBBBBB);
    tick();
    check("rbw_next_vld", 64'(rd_data_valid), 64'd1);
    check("rbw_new", rd_data, 64'hFFFFFFFFFFFFFFFF);
    tick();
    check("rbw_idle_vld", 64'(rd_data_valid), 64'd0);

    // Back-to-back reads of four words.
    do_write(22'h00, 64'hA0A1A2A3A4A5A6A7, 8'hFF);
    do_write(22'h08, 64'hB0B1B2B3B4B5B6B7, 8'hFF);
    do_write(22'h18, 64'hD0D1D2D3D4D5D6D7, 8'hFF);
    burst_exp[0] = 64'hA0A1A2A3A4A5A6A7;
    burst_exp[1] = 64'hB0B1B2B3B4B5B6B7;
    burst_exp[2] = 64'hFFFFFFFFFFFFFFFF;
    burst_exp[3] = 64'hD0D1D2D3D4D5D6D7;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        rd_en = 1'b1; rd_addr = 22'(c * 8);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 4) begin
        check($sformatf("burst%0d_vld", c - 1), 64'(rd_data_valid), 64'd1);
        check($sformatf("burst%0d_data", c - 1), rd_data, burst_exp[c-1]);
      end else begin
        check($sformatf("burst_idle%0d_vld", c), 64'(rd_data_valid), 64'd0);
      end
    end

    // Reset one cycle after a read drops it; writes during reset are ignored.
    rd_en = 1'b1; rd_addr = 22'h08;
    tick();
    rd_en = 1'b0;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 22'h08; wr_data = 64'h0; wr_strb = 8'hFF;
    rd_en = 1'b1; rd_addr = 22'h08;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    reset = 1'b0;
    check("flush_rst_vld", 64'(rd_data_valid), 64'd0);
    check("flush_rst_data", rd_data, 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("flush%0d_vld", c), 64'(rd_data_valid), 64'd0);
    end
    read_check("rst_nowrite", 22'h08, 64'hB0B1B2B3B4B5B6B7);

    // Out-of-range write: dropped with sticky error, or aliased onto word 0.
    do_write(22'h800, 64'hDEADBEEFCAFEF00D, 8'hFF);
`ifdef GLB_PROC_RESP_RANGE_CHECK_EN
    check("oor_err", 64'(err_oor), 64'd1);
    word0 = 64'hA0A1A2A3A4A5A6A7;
    read_check("oor_rd", 22'h800, 64'd0);
    check("oor_sticky", 64'(err_oor), 64'd1);
`else
    check("oor_err", 64'(err_oor), 64'd0);
    word0 = 64'hDEADBEEFCAFEF00D;
    read_check("oor_rd", 22'h800, word0);
    check("oor_sticky", 64'(err_oor), 64'd0);
`endif
    read_check("oor_word0", 22'h00, word0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("oor_err_rst", 64'(err_oor), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/glb_proc_responder.md
GLB_PROC_RESPONDER -- requirements
Module: glb_proc_responder

Interface
REQ-001 SHALL have parameter BANK_DATA_WIDTH, default 64, meaning data word width in bits (multiple of 8).
REQ-002 SHALL have parameter GLB_ADDR_WIDTH, default 22, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of storage words.
REQ-004 SHALL have parameter RD_LATENCY, default 2, legal range 1..4, meaning cycles from rd_en sample to rd_data_valid.
REQ-005 SHALL have a single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 wr_en  input  1  write request for this cycle.
REQ-009 wr_strb  input  BANK_DATA_WIDTH/8  per-byte write enable.
REQ-010 wr_addr  input  GLB_ADDR_WIDTH  byte address of write.
REQ-011 wr_data  input  BANK_DATA_WIDTH  write data.
REQ-012 rd_en  input  1  read request for this cycle.
REQ-013 rd_addr  input  GLB_ADDR_WIDTH  byte address of read.
REQ-014 rd_data  output  BANK_DATA_WIDTH  read response data.
REQ-015 rd_data_valid  output  1  rd_data carries a response this cycle.
REQ-016 err_oor  output  1  sticky out-of-range access flag.

Function
REQ-017 SHALL be the responder end of the processor packet: always ready; every wr_en and rd_en cycle is accepted with no back-pressure.
REQ-018 SHALL form word index = addr[ADDR_LSB +: DEPTH_LOG2], with ADDR_LSB = log2(BANK_DATA_WIDTH/8); byte-offset bits are ignored.
REQ-019 SHALL, on wr_en, update only bytes whose wr_strb bit is 1; wr_strb all-zero is a legal no-op.
REQ-020 SHALL, on rd_en in cycle N, assert rd_data_valid for exactly one cycle in cycle N+RD_LATENCY with the word contents as of cycle N.
REQ-021 SHALL accept back-to-back reads every cycle; responses are returned in issue order with no bubbles inserted.
REQ-022 SHALL, on wr_en and rd_en to the same word in the same cycle, return the pre-write data (read-before-write).
REQ-023 SHALL make a write in cycle N visible to a read issued in cycle N+1 or later.
REQ-024 SHALL drive rd_data to zero whenever rd_data_valid is 0.
REQ-025 SHALL, with the range check disabled, ignore address bits above ADDR_LSB+DEPTH_LOG2 (aliasing/wrap-around).

Reset
REQ-026 SHALL, in any cycle with reset high, clear the read-latency pipeline; rd_data_valid=0, rd_data=0, err_oor=0 in the following cycle.
REQ-027 SHALL drop reads in flight when reset asserts mid-operation; no response emerges after reset deasserts.
REQ-028 SHALL ignore wr_en and rd_en while reset is high.
REQ-029 SHALL NOT clear storage contents on reset; storage is undefined until written.

Configuration
REQ-030 SHALL, when GLB_PROC_RESP_RANGE_CHECK_EN is defined, treat an access with any nonzero address bit above ADDR_LSB+DEPTH_LOG2 as out-of-range: the write is dropped; the read still responds at normal latency with rd_data=0; err_oor sets the following cycle and holds until reset.
REQ-031 SHALL, when GLB_PROC_RESP_RANGE_CHECK_EN is undefined, alias per REQ-025 and tie err_oor to 0.

Verification
REQ-032 Reset, then write 0x1122334455667788 (strb 0xFF) to addr 0x10; read 0x10 -> rd_data_valid pulses exactly 2 cycles later with 0x1122334455667788.
REQ-033 Write strb 0x0F with data 0xAAAAAAAABBBBBBBB over REQ-032 contents; read -> 0x11223344BBBBBBBB.
REQ-034 Same-cycle write 0xFFFF...FF and read at addr 0x10 -> old data returned; a read the next cycle -> 0xFFFF...FF.
REQ-035 Issue 4 consecutive-cycle reads to 0x00, 0x08, 0x10, 0x18 -> 4 consecutive valid cycles, in order, with matching data.
REQ-036 Issue a read, assert reset 1 cycle later -> no rd_data_valid pulse at any time afterward.
REQ-037 With GLB_PROC_RESP_RANGE_CHECK_EN defined: write to 0x800 (DEPTH_LOG2=8) -> word 0 unchanged, err_oor=1 next cycle; without the macro, word 0 is overwritten and err_oor stays 0.
